rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit_pkg.sv | 40 ++++
 rtl/rob_commit_if.sv | 43 ++++
 rtl/rob_entry_array.sv | 71 +++++++
 rtl/rob_commit.sv | 140 ++++++++++++++
 tb/tb_rob_commit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rob_commit_pkg.sv
// Shared reorder-buffer definitions: geometry, pointer type and entry record layout.
// Used by issue, MEM and rob_commit so all stages agree on pointer encoding.
package rob_commit_pkg;

    localparam int unsigned ROB_DEPTH = 32;
    localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);
    localparam int unsigned PTR_W     = IDX_W + 1;

    // Pointer = entry index plus one wrap bit to tell full from empty.
    typedef logic [PTR_W-1:0] rob_ptr_t;

    typedef struct packed {
        logic [4:0]  write_reg;
        logic        do_wb;
        logic [31:0] pc;
    } rob_alloc_t;

    typedef struct packed {
        logic [31:0] result;
        logic        taken_branch;
        logic [31:0] target_pc;
        logic        mem_hazard;
    } rob_cmpl_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        rob_alloc_t alloc;
        rob_cmpl_t  cmpl;
    } rob_entry_t;

    function automatic rob_ptr_t ptr_inc(input rob_ptr_t p);
        return p + rob_ptr_t'(1'b1);
    endfunction

    function automatic logic ptr_full(input rob_ptr_t head, input rob_ptr_t tail);
        return (head[PTR_W-2:0] == tail[PTR_W-2:0]) && (head[PTR_W-1] != tail[PTR_W-1]);
    endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Reorder-buffer bus: allocation, MEM/WB completion, register-file commit and flush.
// The pipeline drives through master; the ROB sits on slave.
interface rob_commit_if;
    import rob_commit_pkg::*;

    logic        alloc_valid;
    logic [4:0]  alloc_writeReg;
    logic        alloc_doWB;
    logic [31:0] alloc_PC;
    logic        alloc_ready;
    rob_ptr_t    alloc_ptr;

    logic        complete_valid;
    rob_ptr_t    complete_ptr;
    logic [31:0] complete_result;
    logic        complete_taken_branch;
    logic [31:0] complete_target_PC;
    logic        complete_mem_hazard;

    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [31:0] commit_data;
    logic        flush;
    logic [31:0] flush_PC;
    rob_ptr_t    count;

    modport master (
        output alloc_valid, alloc_writeReg, alloc_doWB, alloc_PC,
        input  alloc_ready, alloc_ptr,
        output complete_valid, complete_ptr, complete_result,
        output complete_taken_branch, complete_target_PC, complete_mem_hazard,
        input  commit_valid, commit_reg, commit_data, flush, flush_PC, count
    );

    modport slave (
        input  alloc_valid, alloc_writeReg, alloc_doWB, alloc_PC,
        output alloc_ready, alloc_ptr,
        input  complete_valid, complete_ptr, complete_result,
        input  complete_taken_branch, complete_target_PC, complete_mem_hazard,
        output commit_valid, commit_reg, commit_data, flush, flush_PC, count
    );

endinterface

// File: rtl/rob_entry_array.sv
// ROB entry storage: busy/done status with reset, payload RAM without reset.
// One alloc write port, one completion write port, one combinational read port at head.
module rob_entry_array
    import rob_commit_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     alloc_we,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  rob_alloc_t               alloc_data,
    input  logic                     cmpl_we,
    input  logic [$clog2(DEPTH)-1:0] cmpl_idx,
    input  rob_cmpl_t                cmpl_data,
    input  logic                     retire_clr,
    input  logic                     flush_clr,
    input  logic [$clog2(DEPTH)-1:0] head_idx,
    output rob_entry_t               head_entry
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] done_r;
    rob_alloc_t       alloc_mem_r [DEPTH];
    rob_cmpl_t        cmpl_mem_r  [DEPTH];
    logic             cmpl_ok_s;

    // Completions aimed at free (squashed or never allocated) entries are dropped.
    assign cmpl_ok_s = cmpl_we && busy_r[cmpl_idx];

    // Entry status: allocate, complete, retire and squash.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_r <= '0;
            done_r <= '0;
        end else if (flush_clr) begin
            busy_r <= '0;
        end else begin
            if (alloc_we) begin
                busy_r[alloc_idx] <= 1'b1;
                done_r[alloc_idx] <= 1'b0;
            end
            if (cmpl_ok_s) begin
                done_r[cmpl_idx] <= 1'b1;
            end
            if (retire_clr) begin
                busy_r[head_idx] <= 1'b0;
            end
        end
    end

    // Payload storage; contents are meaningless while busy is clear.
    always_ff @(posedge CLK) begin
        if (alloc_we) begin
            alloc_mem_r[alloc_idx] <= alloc_data;
        end
        if (cmpl_ok_s) begin
            cmpl_mem_r[cmpl_idx] <= cmpl_data;
        end
    end

    // Head read port.
    always_comb begin
        head_entry       = '0;
        head_entry.busy  = busy_r[head_idx];
        head_entry.done  = done_r[head_idx];
        head_entry.alloc = alloc_mem_r[head_idx];
        head_entry.cmpl  = cmpl_mem_r[head_idx];
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry retirement, registered commit port
// and flush on taken branch or memory hazard at the head.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         FREEZE,
    rob_commit_if.slave  rob
);

    localparam int unsigned IW = $clog2(DEPTH);

    rob_ptr_t    head_r;
    rob_ptr_t    tail_r;
    rob_ptr_t    count_r;
    logic        commit_valid_r;
    logic [4:0]  commit_reg_r;
    logic [31:0] commit_data_r;
    logic        flush_r;
    logic [31:0] flush_pc_r;

    rob_entry_t  head_entry_s;
    rob_alloc_t  alloc_data_s;
    rob_cmpl_t   in_cmpl_s;
    rob_cmpl_t   head_cmpl_s;
    logic        full_s;
    logic        alloc_ready_s;
    logic        alloc_fire_s;
    logic        cmpl_hit_head_s;
    logic        retire_s;
    logic        retire_flush_s;
    logic        retire_wb_s;
    logic        alloc_we_s;
    logic        cmpl_we_s;

    // Retire decision; full is taken from pre-retire pointers so a freed slot is not reused this cycle.
    always_comb begin
        alloc_data_s              = '0;
        alloc_data_s.write_reg    = rob.alloc_writeReg;
        alloc_data_s.do_wb        = rob.alloc_doWB;
        alloc_data_s.pc           = rob.alloc_PC;
        in_cmpl_s                 = '0;
        in_cmpl_s.result          = rob.complete_result;
        in_cmpl_s.taken_branch    = rob.complete_taken_branch;
        in_cmpl_s.target_pc       = rob.complete_target_PC;
        in_cmpl_s.mem_hazard      = rob.complete_mem_hazard;

        full_s          = ptr_full(head_r, tail_r);
        alloc_ready_s   = !full_s && !FREEZE;
        alloc_fire_s    = rob.alloc_valid && alloc_ready_s;
        cmpl_hit_head_s = rob.complete_valid && (rob.complete_ptr == head_r);

        if (cmpl_hit_head_s) begin
            head_cmpl_s = in_cmpl_s;
        end else begin
            head_cmpl_s = head_entry_s.cmpl;
        end

        retire_s       = !FREEZE && head_entry_s.busy && (head_entry_s.done || cmpl_hit_head_s);
        retire_flush_s = retire_s && (head_cmpl_s.mem_hazard || head_cmpl_s.taken_branch);
        retire_wb_s    = retire_s && head_entry_s.alloc.do_wb && !head_cmpl_s.mem_hazard;
        alloc_we_s     = alloc_fire_s && !retire_flush_s;
        cmpl_we_s      = rob.complete_valid && !FREEZE && !retire_flush_s;
    end

    rob_entry_array #(.DEPTH(DEPTH)) u_entries (
        .CLK        (CLK),
        .RESET      (RESET),
        .alloc_we   (alloc_we_s),
        .alloc_idx  (tail_r[IW-1:0]),
        .alloc_data (alloc_data_s),
        .cmpl_we    (cmpl_we_s),
        .cmpl_idx   (rob.complete_ptr[IW-1:0]),
        .cmpl_data  (in_cmpl_s),
        .retire_clr (retire_s),
        .flush_clr  (retire_flush_s),
        .head_idx   (head_r[IW-1:0]),
        .head_entry (head_entry_s)
    );

    // Head/tail pointers and occupancy; a flush leaves the ROB empty just past the retired entry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (retire_s) begin
                head_r <= ptr_inc(head_r);
            end
            if (retire_flush_s) begin
                tail_r  <= ptr_inc(head_r);
                count_r <= '0;
            end else begin
                if (alloc_fire_s) begin
                    tail_r <= ptr_inc(tail_r);
                end
                case ({alloc_fire_s, retire_s})
                    2'b10:   count_r <= count_r + rob_ptr_t'(1'b1);
                    2'b01:   count_r <= count_r - rob_ptr_t'(1'b1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Registered commit and flush ports, valid the cycle after the retire edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            commit_valid_r <= 1'b0;
            commit_reg_r   <= 5'd0;
            commit_data_r  <= 32'd0;
            flush_r        <= 1'b0;
            flush_pc_r     <= 32'd0;
        end else begin
            commit_valid_r <= retire_wb_s;
            flush_r        <= retire_flush_s;
            if (retire_wb_s) begin
                commit_reg_r  <= head_entry_s.alloc.write_reg;
                commit_data_r <= head_cmpl_s.result;
            end
            if (retire_flush_s) begin
                flush_pc_r <= head_cmpl_s.mem_hazard ? head_entry_s.alloc.pc : head_cmpl_s.target_pc;
            end
        end
    end

    assign rob.alloc_ready  = alloc_ready_s;
    assign rob.alloc_ptr    = tail_r;
    assign rob.commit_valid = commit_valid_r;
    assign rob.commit_reg   = commit_reg_r;
    assign rob.commit_data  = commit_data_r;
    assign rob.flush        = flush_r;
    assign rob.flush_PC     = flush_pc_r;
    assign rob.count        = count_r;

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit: in-order and out-of-order retire,
// full/wrap, branch and memory-hazard flush, FREEZE and mid-stream reset.
module tb_rob_commit;

    logic CLK = 1'b0;
    logic RESET;
    logic FREEZE;
    int   n_checks = 0;
    int   n_errors = 0;

    rob_commit_if bus ();

    rob_commit #(.DEPTH(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .FREEZE (FREEZE),
        .rob    (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample point is #1 after it; one-shot requests are dropped.
    task automatic step();
        @(posedge CLK);
        #1;
        bus.alloc_valid           = 1'b0;
        bus.complete_valid        = 1'b0;
        bus.complete_taken_branch = 1'b0;
        bus.complete_mem_hazard   = 1'b0;
    endtask

    task automatic drive_alloc(input logic [4:0] rd, input logic wb, input logic [31:0] pc);
        bus.alloc_valid    = 1'b1;
        bus.alloc_writeReg = rd;
        bus.alloc_doWB     = wb;
        bus.alloc_PC       = pc;
    endtask

    task automatic drive_cmpl(input logic [5:0] ptr, input logic [31:0] res, input logic br,
                              input logic [31:0] tgt, input logic mh);
        bus.complete_valid        = 1'b1;
        bus.complete_ptr          = ptr;
        bus.complete_result       = res;
        bus.complete_taken_branch = br;
        bus.complete_target_PC    = tgt;
        bus.complete_mem_hazard   = mh;
    endtask

    task automatic check_commit(input string tag, input logic cv, input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, "_valid"}, 32'(bus.commit_valid), 32'(cv));
        check_eq({tag, "_reg"},   32'(bus.commit_reg),   32'(rd));
        check_eq({tag, "_data"},  bus.commit_data,       data);
    endtask

    initial begin
        RESET  = 1'b1;
        FREEZE = 1'b0;
        bus.alloc_valid = 1'b0;  bus.alloc_writeReg = 5'd0; bus.alloc_doWB = 1'b0; bus.alloc_PC = 32'd0;
        bus.complete_valid = 1'b0; bus.complete_ptr = 6'd0; bus.complete_result = 32'd0;
        bus.complete_taken_branch = 1'b0; bus.complete_target_PC = 32'd0; bus.complete_mem_hazard = 1'b0;
        step();
        step();
        check_commit("rst_commit", 1'b0, 5'd0, 32'd0);
        check_eq("rst_flush",       32'(bus.flush),       32'd0);
        check_eq("rst_flush_pc",    bus.flush_PC,         32'd0);
        check_eq("rst_count",       32'(bus.count),       32'd0);
        check_eq("rst_alloc_ptr",   32'(bus.alloc_ptr),   32'd0);
        check_eq("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        RESET = 1'b0;

        // In-order completion: regs 1..3 get 0xA..0xC on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            check_eq("inord_alloc_ptr", 32'(bus.alloc_ptr), 32'(i));
            drive_alloc(5'(i + 1), 1'b1, 32'h100 + 32'(i * 4));
            step();
        end
        check_eq("inord_count3", 32'(bus.count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive_cmpl(6'(i), 32'hA + 32'(i), 1'b0, 32'd0, 1'b0);
            step();
            check_commit("inord_commit", 1'b1, 5'(i + 1), 32'hA + 32'(i));
        end
        check_eq("inord_count0", 32'(bus.count), 32'd0);
        step();
        check_eq("inord_idle_cv", 32'(bus.commit_valid), 32'd0);

        // Out-of-order completion on ptrs 3..5: nothing retires until ptr 3 is done.
        for (int i = 0; i < 3; i++) begin
            drive_alloc(5'(i + 4), 1'b1, 32'h140 + 32'(i * 4));
            step();
        end
        drive_cmpl(6'd5, 32'h55, 1'b0, 32'd0, 1'b0);
        step();
        check_eq("ooo_wait5_cv", 32'(bus.commit_valid), 32'd0);
        drive_cmpl(6'd4, 32'h44, 1'b0, 32'd0, 1'b0);
        step();
        check_eq("ooo_wait4_cv", 32'(bus.commit_valid), 32'd0);
        check_eq("ooo_wait_count", 32'(bus.count), 32'd3);
        drive_cmpl(6'd3, 32'h33, 1'b0, 32'd0, 1'b0);
        step();
        check_commit("ooo_c0", 1'b1, 5'd4, 32'h33);
        step();
        check_commit("ooo_c1", 1'b1, 5'd5, 32'h44);
        step();
        check_commit("ooo_c2", 1'b1, 5'd6, 32'h55);
        check_eq("ooo_count0", 32'(bus.count), 32'd0);
        step();
        check_eq("ooo_idle_cv", 32'(bus.commit_valid), 32'd0);

        // Fill 32 entries (ptrs 6..37), then retire one and stream alloc+retire across the wrap.
        for (int i = 0; i < 32; i++) begin
            drive_alloc(5'(i + 7), 1'b1, 32'h1000 + 32'(i * 4));
            step();
        end
        check_eq("full_ready", 32'(bus.alloc_ready), 32'd0);
        check_eq("full_count", 32'(bus.count), 32'd32);
        check_eq("full_tail",  32'(bus.alloc_ptr), 32'd38);
        drive_alloc(5'd31, 1'b1, 32'h2000);
        drive_cmpl(6'd6, 32'h600, 1'b0, 32'd0, 1'b0);
        step();
        check_commit("full_retire", 1'b1, 5'd7, 32'h600);
        check_eq("full_retire_count", 32'(bus.count), 32'd31);
        check_eq("full_retire_ready", 32'(bus.alloc_ready), 32'd1);
        check_eq("full_blocked_tail", 32'(bus.alloc_ptr), 32'd38);
        for (int k = 0; k < 26; k++) begin
            if (k == 25) check_eq("wrap_ptr63", 32'(bus.alloc_ptr), 32'd63);
            drive_alloc(5'd9, 1'b1, 32'h3000 + 32'(k * 4));
            drive_cmpl(6'(7 + k), 32'(k), 1'b0, 32'd0, 1'b0);
            step();
        end
        check_eq("wrap_ptr0",   32'(bus.alloc_ptr), 32'd0);
        check_eq("wrap_count",  32'(bus.count), 32'd31);
        check_eq("wrap_cv",     32'(bus.commit_valid), 32'd1);
        check_eq("wrap_data",   bus.commit_data, 32'd25);

        // Reset mid-stream with requests pending.
        drive_alloc(5'd3, 1'b1, 32'h4000);
        drive_cmpl(6'd33, 32'hFF, 1'b1, 32'h500, 1'b0);
        RESET = 1'b1;
        step();
        check_commit("mid_rst", 1'b0, 5'd0, 32'd0);
        check_eq("mid_rst_flush",    32'(bus.flush), 32'd0);
        check_eq("mid_rst_flush_pc", bus.flush_PC, 32'd0);
        check_eq("mid_rst_count",    32'(bus.count), 32'd0);
        check_eq("mid_rst_tail",     32'(bus.alloc_ptr), 32'd0);
        RESET = 1'b0;

        // Taken branch at head with 4 younger busy entries; same-cycle alloc is squashed.
        for (int i = 0; i < 5; i++) begin
            drive_alloc(5'(i + 10), 1'b1, 32'h200 + 32'(i * 4));
            step();
        end
        drive_cmpl(6'd0, 32'h77, 1'b1, 32'h400, 1'b0);
        drive_alloc(5'd15, 1'b1, 32'h300);
        step();
        check_commit("br_commit", 1'b1, 5'd10, 32'h77);
        check_eq("br_flush",    32'(bus.flush), 32'd1);
        check_eq("br_flush_pc", bus.flush_PC, 32'h400);
        check_eq("br_count",    32'(bus.count), 32'd0);
        check_eq("br_tail",     32'(bus.alloc_ptr), 32'd1);
        drive_cmpl(6'd2, 32'h88, 1'b0, 32'd0, 1'b0);
        step();
        check_eq("squashed_cv",    32'(bus.commit_valid), 32'd0);
        check_eq("flush_pulse",    32'(bus.flush), 32'd0);
        check_eq("squashed_count", 32'(bus.count), 32'd0);

        // Memory hazard at head: no writeback, redirect to the entry PC.
        drive_alloc(5'd20, 1'b1, 32'h120);
        step();
        check_eq("mh_count1", 32'(bus.count), 32'd1);
        drive_cmpl(6'd1, 32'h99, 1'b0, 32'd0, 1'b1);
        step();
        check_eq("mh_cv",       32'(bus.commit_valid), 32'd0);
        check_eq("mh_flush",    32'(bus.flush), 32'd1);
        check_eq("mh_flush_pc", bus.flush_PC, 32'h120);
        check_eq("mh_count",    32'(bus.count), 32'd0);
        check_eq("mh_tail",     32'(bus.alloc_ptr), 32'd2);

        // FREEZE holds a pending head completion, then it retires once released.
        drive_alloc(5'd21, 1'b1, 32'h300);
        step();
        FREEZE = 1'b1;
        #1;
        check_eq("frz_ready", 32'(bus.alloc_ready), 32'd0);
        drive_cmpl(6'd2, 32'hAB, 1'b0, 32'd0, 1'b0);
        drive_alloc(5'd22, 1'b1, 32'h304);
        step();
        check_eq("frz_cv",    32'(bus.commit_valid), 32'd0);
        check_eq("frz_count", 32'(bus.count), 32'd1);
        check_eq("frz_tail",  32'(bus.alloc_ptr), 32'd3);
        FREEZE = 1'b0;
        drive_cmpl(6'd2, 32'hAB, 1'b0, 32'd0, 1'b0);
        step();
        check_commit("unfrz_commit", 1'b1, 5'd21, 32'hAB);
        check_eq("unfrz_count", 32'(bus.count), 32'd0);

        // doWB clear: retires without a register-file write.
        drive_alloc(5'd23, 1'b0, 32'h308);
        step();
        drive_cmpl(6'd3, 32'hCD, 1'b0, 32'd0, 1'b0);
        step();
        check_eq("nowb_cv",    32'(bus.commit_valid), 32'd0);
        check_eq("nowb_flush", 32'(bus.flush), 32'd0);
        check_eq("nowb_count", 32'(bus.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
